// File: rtl/gpu_isa_pkg.sv
// Shared ISA definitions for the GPU toolchain blocks.
// Holds the 4-bit opcode constants and the program-load FSM state type.
// Used by the instruction decoder, the program encoder and its field packer.
package gpu_isa_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_BRNZP = 4'h1;
  localparam logic [3:0] OP_CMP   = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_MUL   = 4'h5;
  localparam logic [3:0] OP_DIV   = 4'h6;
  localparam logic [3:0] OP_LDR   = 4'h7;
  localparam logic [3:0] OP_STR   = 4'h8;
  localparam logic [3:0] OP_CONST = 4'h9;
  localparam logic [3:0] OP_FMA   = 4'hA;
  localparam logic [3:0] OP_ACT   = 4'hB;
  localparam logic [3:0] OP_RET   = 4'hF;

  // Program-load sequencing: wait for start, stream words, pulse done.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } enc_state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational instruction packer.
// Inputs : opcode, register fields rd/rs/rt, nzp condition, 8-bit immediate,
//          2-bit activation function selector.
// Outputs: word     - 16-bit encoded instruction (opcode in [15:12])
//          illegal  - opcode is in the reserved range (not encodable)
//          conflict - ACT whose rd[1:0] disagrees with act_func
module instr_pack
  import gpu_isa_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [3:0]  rd,
  input  logic [3:0]  rs,
  input  logic [3:0]  rt,
  input  logic [2:0]  nzp,
  input  logic [7:0]  imm,
  input  logic [1:0]  act_func,
  output logic [15:0] word,
  output logic        illegal,
  output logic        conflict
);

  // Only the fields each format uses are copied; everything else stays zero
  // so stray input values never leak into the program image.
  always_comb begin
    word     = 16'h0000;
    illegal  = 1'b0;
    conflict = 1'b0;
    case (opcode)
      OP_NOP, OP_RET:                       word = {opcode, 12'h000};
      OP_BRNZP:                             word = {opcode, nzp, 1'b0, imm};
      OP_CMP, OP_STR:                       word = {opcode, rs, rt, 4'h0};
      OP_ADD, OP_SUB, OP_MUL, OP_DIV,
      OP_FMA:                               word = {opcode, rd, rs, rt};
      OP_LDR:                               word = {opcode, rd, rs, 4'h0};
      OP_CONST:                             word = {opcode, rd, imm};
      OP_ACT: begin
        // act_func is authoritative for [9:8]; a disagreeing rd is flagged.
        word     = {opcode, rd[3:2], act_func, rs, rt};
        conflict = (rd[1:0] != act_func);
      end
      default:                              illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/program_encoder.sv
// Program encoder: accepts decoded instruction fields, packs them into 16-bit
// words and writes them to consecutive program-memory addresses.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start/base_addr/length- begin a load of `length` words at `base_addr`
//   in_*                  - valid/ready instruction field stream
//   mem_write_*           - valid/ready memory write port (FIFO head)
//   busy/done/error       - status; error is sticky until the next start
module program_encoder
  import gpu_isa_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  base_addr,
  input  logic [7:0]  length,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_rs,
  input  logic [3:0]  in_rt,
  input  logic [2:0]  in_nzp,
  input  logic [7:0]  in_imm,
  input  logic [1:0]  in_act_func,
  output logic        mem_write_valid,
  input  logic        mem_write_ready,
  output logic [7:0]  mem_write_address,
  output logic [15:0] mem_write_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  enc_state_t  state_q, state_d;
  logic [15:0] fifo_data_q [2];
  logic [15:0] fifo_data_d [2];
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [7:0]  acc_cnt_q, acc_cnt_d;
  logic [7:0]  wr_cnt_q, wr_cnt_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  addr_q, addr_d;
  logic        error_q, error_d;

  logic [15:0] packed_word;
  logic        pack_illegal;
  logic        pack_conflict;
  logic        ready_c;
  logic        accept;
  logic        push;
  logic        pop;
  logic [1:0]  occ_after_pop;

  instr_pack u_pack (
    .opcode   (in_opcode),
    .rd       (in_rd),
    .rs       (in_rs),
    .rt       (in_rt),
    .nzp      (in_nzp),
    .imm      (in_imm),
    .act_func (in_act_func),
    .word     (packed_word),
    .illegal  (pack_illegal),
    .conflict (pack_conflict)
  );

  always_comb begin
    state_d        = state_q;
    fifo_data_d[0] = fifo_data_q[0];
    fifo_data_d[1] = fifo_data_q[1];
    fifo_cnt_d     = fifo_cnt_q;
    acc_cnt_d      = acc_cnt_q;
    wr_cnt_d       = wr_cnt_q;
    len_d          = len_q;
    addr_d         = addr_q;
    error_d        = error_q;

    // Accepted count stops intake once all legal words are in flight.
    ready_c = (state_q == ST_LOAD) && (fifo_cnt_q != 2'd2) && (acc_cnt_q < len_q);
    accept  = in_valid && ready_c;
    push    = accept && !pack_illegal;
    pop     = (fifo_cnt_q != 2'd0) && mem_write_ready;

    // Pop shifts slot 1 forward; a same-cycle push lands in the first slot
    // left free after that shift, so push+pop never creates a bubble.
    occ_after_pop = fifo_cnt_q - {1'b0, pop};
    if (pop) begin
      fifo_data_d[0] = fifo_data_q[1];
      wr_cnt_d       = wr_cnt_q + 8'd1;
      addr_d         = addr_q + 8'd1;
    end
    if (push) begin
      fifo_data_d[occ_after_pop[0]] = packed_word;
      acc_cnt_d                     = acc_cnt_q + 8'd1;
    end
    fifo_cnt_d = occ_after_pop + {1'b0, push};

    if (accept && (pack_illegal || pack_conflict)) begin
      error_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          addr_d     = base_addr;
          len_d      = length;
          acc_cnt_d  = 8'd0;
          wr_cnt_d   = 8'd0;
          fifo_cnt_d = 2'd0;
          error_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        if (wr_cnt_q == len_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      fifo_data_q[0] <= 16'h0000;
      fifo_data_q[1] <= 16'h0000;
      fifo_cnt_q     <= 2'd0;
      acc_cnt_q      <= 8'd0;
      wr_cnt_q       <= 8'd0;
      len_q          <= 8'd0;
      addr_q         <= 8'd0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      fifo_data_q[0] <= fifo_data_d[0];
      fifo_data_q[1] <= fifo_data_d[1];
      fifo_cnt_q     <= fifo_cnt_d;
      acc_cnt_q      <= acc_cnt_d;
      wr_cnt_q       <= wr_cnt_d;
      len_q          <= len_d;
      addr_q         <= addr_d;
      error_q        <= error_d;
    end
  end

  assign in_ready          = ready_c;
  assign mem_write_valid   = (fifo_cnt_q != 2'd0);
  assign mem_write_address = addr_q;
  assign mem_write_data    = fifo_data_q[0];
  assign busy              = (state_q != ST_IDLE);
  assign done              = (state_q == ST_DONE);
  assign error             = error_q;

endmodule

// File: tb/tb_program_encoder.sv
// Directed self-checking bench for program_encoder.
module tb_program_encoder;

   typedef struct packed {
      logic [3:0] op;
      logic [3:0] rd;
      logic [3:0] rs;
      logic [3:0] rt;
      logic [2:0] nzp;
      logic [7:0] imm;
      logic [1:0] func;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  base_addr;
   logic [7:0]  length;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_opcode;
   logic [3:0]  in_rd;
   logic [3:0]  in_rs;
   logic [3:0]  in_rt;
   logic [2:0]  in_nzp;
   logic [7:0]  in_imm;
   logic [1:0]  in_act_func;
   logic        mem_write_valid;
   logic        mem_write_ready;
   logic [7:0]  mem_write_address;
   logic [15:0] mem_write_data;
   logic        busy;
   logic        done;
   logic        error;

   int checksTotal = 0;
   int checksPassed = 0;

   vec_t        vecs[$];
   logic [23:0] expWrites[$];
   logic [23:0] writeLog[$];
   int          doneCount = 0;
   int          holdErrors = 0;
   int          holdChecks = 0;
   logic        holdValid = 1'b0;
   logic [7:0]  holdAddr = 8'h00;
   logic [15:0] holdData = 16'h0000;
   int          logBase;
   int          doneBase;

   program_encoder dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .base_addr         (base_addr),
      .length            (length),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_opcode         (in_opcode),
      .in_rd             (in_rd),
      .in_rs             (in_rs),
      .in_rt             (in_rt),
      .in_nzp            (in_nzp),
      .in_imm            (in_imm),
      .in_act_func       (in_act_func),
      .mem_write_valid   (mem_write_valid),
      .mem_write_ready   (mem_write_ready),
      .mem_write_address (mem_write_address),
      .mem_write_data    (mem_write_data),
      .busy              (busy),
      .done              (done),
      .error             (error)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Passive monitor on the falling edge: logs completed writes, counts done
   // pulses, and verifies the head stays put while the memory stalls.
   always @(negedge clk) begin
      if (!reset) begin
         if (done) doneCount++;
         if (holdValid) begin
            holdChecks++;
            if (!mem_write_valid || mem_write_address != holdAddr || mem_write_data != holdData)
               holdErrors++;
         end
         if (mem_write_valid && mem_write_ready)
            writeLog.push_back({mem_write_address, mem_write_data});
         holdValid = mem_write_valid && !mem_write_ready;
         holdAddr  = mem_write_address;
         holdData  = mem_write_data;
      end
   end

   function automatic vec_t mk(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                               input logic [3:0] rt, input logic [2:0] nzp, input logic [7:0] imm,
                               input logic [1:0] func);
      vec_t v;
      v.op = op; v.rd = rd; v.rs = rs; v.rt = rt; v.nzp = nzp; v.imm = imm; v.func = func;
      return v;
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checksTotal++;
      if (observed === expected) checksPassed++;
      else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   // Runs one load: start pulse, then streams vecs with in_valid held high.
   // Memory ready is low for cycles [stallFrom, stallFrom+stallLen).
   // abortAfter >= 0 asserts reset once that many writes have been logged.
   task automatic applyStimulus(input logic [7:0] base, input logic [7:0] len, input int stallFrom,
                                input int stallLen, input int abortAfter);
      int  idx;
      int  accCount;
      bit  acc;
      bit  finished;
      logBase  = writeLog.size();
      doneBase = doneCount;
      @(posedge clk); #1;
      start = 1'b1; base_addr = base; length = len;
      @(posedge clk); #1;
      start = 1'b0;
      idx = 0; accCount = 0; finished = 0;
      for (int cyc = 0; cyc < 150 && !finished; cyc++) begin
         in_valid = (idx < vecs.size());
         if (in_valid) begin
            in_opcode = vecs[idx].op; in_rd = vecs[idx].rd; in_rs = vecs[idx].rs;
            in_rt = vecs[idx].rt; in_nzp = vecs[idx].nzp; in_imm = vecs[idx].imm;
            in_act_func = vecs[idx].func;
         end
         mem_write_ready = !(cyc >= stallFrom && cyc < stallFrom + stallLen);
         @(negedge clk); #1;
         acc = in_valid && in_ready;
         if (cyc == 0) checkOutput("noEarlyValid", {31'd0, mem_write_valid}, 32'd0);
         if (cyc == 1 && len != 8'd0) checkOutput("validAfterAccept", {31'd0, mem_write_valid}, 32'd1);
         if (stallLen > 0 && cyc == stallFrom + stallLen - 1) begin
            checkOutput("stallInReady", {31'd0, in_ready}, 32'd0);
            checkOutput("stallAccepts", accCount, 32'd2);
         end
         if (acc) accCount++;
         if (doneCount > doneBase) finished = 1;
         if (abortAfter >= 0 && (writeLog.size() - logBase) >= abortAfter) begin
            @(posedge clk); #1;
            reset = 1'b1; in_valid = 1'b0; mem_write_ready = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            acc = 0; finished = 1;
            checkOutput("abortValid", {31'd0, mem_write_valid}, 32'd0);
            checkOutput("abortBusy", {31'd0, busy}, 32'd0);
            checkOutput("abortInReady", {31'd0, in_ready}, 32'd0);
            checkOutput("abortAddr", {24'd0, mem_write_address}, 32'd0);
         end
         @(posedge clk); #1;
         if (acc) idx++;
      end
      in_valid = 1'b0;
      mem_write_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Compares the logged writes and end-of-load status to the expectations.
   task automatic checkLoad(input string tag, input logic expErr, input int expDone);
      logic [23:0] obs;
      checkOutput({tag, "WriteCount"}, writeLog.size() - logBase, expWrites.size());
      foreach (expWrites[i]) begin
         obs = (logBase + i < writeLog.size()) ? writeLog[logBase + i] : 24'hEEEEEE;
         checkOutput($sformatf("%sWrite%0d", tag, i), {8'd0, obs}, {8'd0, expWrites[i]});
      end
      checkOutput({tag, "Done"}, doneCount - doneBase, expDone);
      checkOutput({tag, "Error"}, {31'd0, error}, {31'd0, expErr});
      checkOutput({tag, "Busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "Hold"}, holdErrors, 32'd0);
   endtask

   initial begin
      int holdBase;
      reset = 1'b1; start = 1'b0; base_addr = 8'h00; length = 8'h00;
      in_valid = 1'b0; in_opcode = 4'h0; in_rd = 4'h0; in_rs = 4'h0; in_rt = 4'h0;
      in_nzp = 3'h0; in_imm = 8'h00; in_act_func = 2'h0; mem_write_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstInReady", {31'd0, in_ready}, 32'd0);
      checkOutput("rstValid", {31'd0, mem_write_valid}, 32'd0);
      checkOutput("rstBusy", {31'd0, busy}, 32'd0);
      checkOutput("rstDone", {31'd0, done}, 32'd0);
      checkOutput("rstError", {31'd0, error}, 32'd0);
      checkOutput("rstAddr", {24'd0, mem_write_address}, 32'd0);
      reset = 1'b0;

      // Basic load
      vecs.delete(); expWrites.delete();
      vecs.push_back(mk(4'h3, 4'd3, 4'd4, 4'd5, 3'd0, 8'h00, 2'd0));
      vecs.push_back(mk(4'h9, 4'd2, 4'd0, 4'd0, 3'd0, 8'h7F, 2'd0));
      vecs.push_back(mk(4'hF, 4'd1, 4'd2, 4'd3, 3'd5, 8'h44, 2'd1));
      expWrites.push_back(24'h103345);
      expWrites.push_back(24'h11927F);
      expWrites.push_back(24'h12F000);
      applyStimulus(8'h10, 8'd3, 0, 0, -1);
      checkLoad("basic", 1'b0, 1);

      // Format coverage with junk in unused fields
      vecs.delete(); expWrites.delete();
      vecs.push_back(mk(4'h1, 4'hF, 4'hF, 4'hF, 3'd4, 8'h05, 2'd3));
      vecs.push_back(mk(4'h8, 4'hF, 4'd7, 4'd8, 3'd7, 8'hFF, 2'd3));
      vecs.push_back(mk(4'hB, 4'd6, 4'd1, 4'd2, 3'd7, 8'hFF, 2'd2));
      vecs.push_back(mk(4'hA, 4'hA, 4'hB, 4'hC, 3'd7, 8'hFF, 2'd3));
      expWrites.push_back(24'h201805);
      expWrites.push_back(24'h218780);
      expWrites.push_back(24'h22B612);
      expWrites.push_back(24'h23AABC);
      applyStimulus(8'h20, 8'd4, 0, 0, -1);
      checkLoad("formats", 1'b0, 1);

      // ACT whose rd[1:0] disagrees with act_func
      vecs.delete(); expWrites.delete();
      vecs.push_back(mk(4'hB, 4'd4, 4'd3, 4'd5, 3'd0, 8'h00, 2'd2));
      expWrites.push_back(24'h24B635);
      applyStimulus(8'h24, 8'd1, 0, 0, -1);
      checkLoad("actConflict", 1'b1, 1);

      // Length zero: done two cycles after start, no writes, error cleared
      logBase = writeLog.size();
      @(posedge clk); #1;
      start = 1'b1; base_addr = 8'h77; length = 8'd0;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("len0DoneEarly", {31'd0, done}, 32'd0);
      checkOutput("len0Busy", {31'd0, busy}, 32'd1);
      checkOutput("len0Error", {31'd0, error}, 32'd0);
      @(posedge clk); #1;
      checkOutput("len0Done", {31'd0, done}, 32'd1);
      @(posedge clk); #1;
      checkOutput("len0DoneEnd", {31'd0, done}, 32'd0);
      checkOutput("len0Idle", {31'd0, busy}, 32'd0);
      checkOutput("len0Writes", writeLog.size() - logBase, 32'd0);

      // Address wrap with an illegal opcode in the stream
      vecs.delete(); expWrites.delete();
      vecs.push_back(mk(4'h9, 4'd1, 4'd0, 4'd0, 3'd0, 8'h11, 2'd0));
      vecs.push_back(mk(4'hD, 4'd5, 4'd6, 4'd7, 3'd1, 8'h99, 2'd1));
      vecs.push_back(mk(4'h2, 4'hF, 4'd2, 4'd3, 3'd7, 8'hFF, 2'd3));
      vecs.push_back(mk(4'h0, 4'd5, 4'd6, 4'd7, 3'd7, 8'hAA, 2'd1));
      expWrites.push_back(24'hFE9111);
      expWrites.push_back(24'hFF2230);
      expWrites.push_back(24'h000000);
      applyStimulus(8'hFE, 8'd3, 0, 0, -1);
      checkLoad("wrap", 1'b1, 1);

      // Backpressure: memory stalls for five cycles from the first accept
      vecs.delete(); expWrites.delete();
      vecs.push_back(mk(4'h3, 4'd1, 4'd2, 4'd3, 3'd0, 8'h00, 2'd0));
      vecs.push_back(mk(4'h4, 4'd4, 4'd5, 4'd6, 3'd0, 8'h00, 2'd0));
      vecs.push_back(mk(4'h5, 4'd7, 4'd8, 4'd9, 3'd0, 8'h00, 2'd0));
      vecs.push_back(mk(4'h7, 4'hA, 4'hB, 4'hC, 3'd0, 8'h00, 2'd0));
      expWrites.push_back(24'h403123);
      expWrites.push_back(24'h414456);
      expWrites.push_back(24'h425789);
      expWrites.push_back(24'h437AB0);
      holdBase = holdChecks;
      applyStimulus(8'h40, 8'd4, 0, 5, -1);
      checkLoad("backpressure", 1'b0, 1);
      checkOutput("bpHoldCycles", holdChecks - holdBase, 32'd4);

      // Reset after the first of four writes
      expWrites.delete();
      expWrites.push_back(24'h303123);
      applyStimulus(8'h30, 8'd4, 0, 0, 1);
      checkLoad("abort", 1'b0, 0);

      // A fresh load after the abort
      vecs.delete(); expWrites.delete();
      vecs.push_back(mk(4'h9, 4'd1, 4'd0, 4'd0, 3'd0, 8'h22, 2'd0));
      expWrites.push_back(24'h509122);
      applyStimulus(8'h50, 8'd1, 0, 0, -1);
      checkLoad("restart", 1'b0, 1);

      $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

   // Absolute guard so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/program_encoder.md
PROGRAM_ENCODER -- requirements
Module: program_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  reset, synchronous, active-high.
REQ-002 SHALL have: start  in  1  one-cycle pulse, begins load; base_addr  in  8  first program-memory address; length  in  8  number of words to write.
REQ-003 SHALL have: in_valid  in  1; in_ready  out  1; in_opcode  in  4; in_rd, in_rs, in_rt  in  4 each; in_nzp  in  3; in_imm  in  8; in_act_func  in  2.
REQ-004 SHALL have: mem_write_valid  out  1; mem_write_ready  in  1; mem_write_address  out  8; mem_write_data  out  16.
REQ-005 SHALL have: busy  out  1  high outside IDLE; done  out  1  one-cycle pulse; error  out  1  sticky until next accepted start.

Function
REQ-006 SHALL implement FSM IDLE -> LOAD (start in IDLE) -> DONE (written count == length) -> IDLE after one cycle; start outside IDLE SHALL be ignored.
REQ-007 SHALL assert done for exactly the DONE cycle; length 0 SHALL go LOAD -> DONE on the next cycle with no writes.
REQ-008 SHALL assert in_ready = LOAD and FIFO not full and accepted count < length; transfer occurs when in_valid and in_ready are both high.
REQ-009 SHALL pack accepted words into a 2-entry FIFO; FIFO head SHALL drive mem_write_*; the earliest mem_write_valid is the cycle after acceptance.
REQ-010 SHALL hold mem_write_address/data stable while mem_write_valid and not mem_write_ready; a write completes on valid and ready.
REQ-011 SHALL allow simultaneous FIFO push and pop in one cycle, with no bubble and no loss.
REQ-012 SHALL start the address at base_addr and increment by 1 per completed write, wrapping 255 -> 0.
REQ-013 SHALL encode each opcode into [15:12]=opcode and [11:0] as follows:
- NOP: 0x000
- BRnzp: {nzp, 0, imm}
- CMP and STR: {rs, rt, 0000}
- ADD/SUB/MUL/DIV/FMA: {rd, rs, rt}
- LDR: {rd, rs, 0000}
- CONST: {rd, imm}
- ACT: {rd[3:2], act_func, rs, rt}
- RET: 0x000
REQ-014 SHALL, for ACT with rd[1:0] != act_func, set error and still write using act_func in [9:8].
REQ-015 SHALL consume an illegal opcode (1100-1110): set error, do not write it, and do not count it toward length.
REQ-016 SHALL keep the unused fields of every legal opcode at zero, regardless of input values.

Reset
REQ-017 SHALL on reset: state IDLE, FIFO flushed, counts and address 0, and in_ready, mem_write_valid, busy, done, error all 0.
REQ-018 SHALL on reset during LOAD abort immediately: no further writes and no done pulse.

Structure
REQ-019 SHALL take opcode constants (NOP..RET, 4-bit) and FSM state enum from shared package gpu_isa_pkg, which the instruction decoder also uses.
REQ-020 SHALL place field packing in a combinational sub-module instr_pack (fields in -> 16-bit word, illegal/conflict flags out); FIFO and FSM stay in program_encoder.

Verification
REQ-021 Basic load: base 0x10, length 3, words ADD rd3 rs4 rt5; CONST rd2 imm 0x7F; RET, ready always 1 -> writes 0x10:0x3345, 0x11:0x927F, 0x12:0xF000, then one done pulse, error 0.
REQ-022 Formats: BRnzp nzp 100 imm 0x05 -> 0x1805; STR rs7 rt8 -> 0x8780; ACT rd6 func 10 rs1 rt2 -> 0xB612, error 0; ACT rd4 func 10 -> error 1.
REQ-023 Backpressure: mem_write_ready low for 5 cycles, in_valid held high -> in_ready drops after 2 accepts, address/data stable, no word lost or duplicated.
REQ-024 Wrap and illegal: base 0xFE, length 3, stream contains opcode 1101 -> it is skipped, error 1, writes go to 0xFE, 0xFF, 0x00.
REQ-025 Reset mid-load: reset asserted after 1 of 4 writes -> no further mem_write_valid, no done, all outputs 0; a new start succeeds.
REQ-026 Length 0: start with length 0 -> no writes, done pulses 2 cycles after start.
